// File: rtl/jk_cmd_debounce.sv
// Purpose: synchronise + debounce set/clear/toggle buttons into fixed-length j/k command pulses.
// Latency: j/k rise after edge DEBOUNCE_CYCLES+2, counting edge 1 as the first to sample a raw press.
// Backpressure: none; presses arriving while busy are dropped, never queued.
//
// Ports:
//   clk      rising-edge clock
//   reset    asynchronous active-low reset
//   set_btn  raw set button (async, active-high)
//   clr_btn  raw clear button (async, active-high)
//   tgl_btn  raw toggle button (async, active-high)
//   j, k     registered command outputs to the JK flip-flop
//   busy     high while a pulse is driven or buttons are still held
module jk_cmd_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int PULSE_CYCLES    = 2,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES) + 1
) (
  input  logic clk,
  input  logic reset,
  input  logic set_btn,
  input  logic clr_btn,
  input  logic tgl_btn,
  output logic j,
  output logic k,
  output logic busy
);

  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam int                PCNT_W    = $clog2(PULSE_CYCLES + 1);
  localparam logic [PCNT_W-1:0] PCNT_LAST = PCNT_W'(PULSE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PULSE        = 2'd1,
    WAIT_RELEASE = 2'd2
  } state_t;

  // Bit order everywhere: [0]=set, [1]=clr, [2]=tgl.
  logic [2:0]       raw;
  logic [2:0]       s1;
  logic [2:0]       s2;
  logic [2:0]       stable;
  logic [CNT_W-1:0] cnt [3];
  logic [2:0]       press;
  logic             any_press;
  logic             cmd_j;
  logic             cmd_k;

  state_t            state;
  logic [PCNT_W-1:0] pcnt;

  assign raw = {tgl_btn, clr_btn, set_btn};

  // Two-flop synchroniser for each asynchronous button.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // A level is accepted only after it has differed from the stable value for
  // DEBOUNCE_CYCLES consecutive samples; any return to the stable value
  // restarts the count, so short bounces are swallowed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < 3; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // press is the cycle on which a 0->1 level is about to be accepted, so the
  // FSM loads its command on the same edge that stable goes high.
  always_comb begin
    press = '0;
    for (int i = 0; i < 3; i++) begin
      press[i] = s2[i] & ~stable[i] & (cnt[i] == CNT_LAST);
    end
  end

  // Toggle, or set and clear together, both mean j=k=1.
  assign any_press = |press;
  assign cmd_j     = press[2] | press[0];
  assign cmd_k     = press[2] | press[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pcnt  <= '0;
      j     <= 1'b0;
      k     <= 1'b0;
      busy  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_press) begin
            state <= PULSE;
            pcnt  <= '0;
            j     <= cmd_j;
            k     <= cmd_k;
            busy  <= 1'b1;
          end
        end
        PULSE: begin
          // Pulse length is fixed; a release during it is only seen later.
          if (pcnt == PCNT_LAST) begin
            state <= WAIT_RELEASE;
            j     <= 1'b0;
            k     <= 1'b0;
          end else begin
            pcnt <= pcnt + 1'b1;
          end
        end
        WAIT_RELEASE: begin
          if (stable == 3'b000) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          j     <= 1'b0;
          k     <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_cmd_debounce.sv
// Purpose: directed stimulus with a scoreboard of expected j/k pulses for jk_cmd_debounce.
// Latency: each expected pulse carries the cycle its first high sample must appear on.
// Backpressure: n/a; the monitor pops one entry per observed pulse.
module tb_jk_cmd_debounce;

  localparam int DEB   = 4;
  localparam int PULSE = 2;

  logic clk = 1'b0;
  logic reset;
  logic set_btn;
  logic clr_btn;
  logic tgl_btn;
  logic j;
  logic k;
  logic busy;

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  typedef struct {
    logic [1:0] jk;
    int         start;
  } exp_t;

  exp_t q[$];

  jk_cmd_debounce #(
    .DEBOUNCE_CYCLES(DEB),
    .PULSE_CYCLES   (PULSE)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .set_btn(set_btn),
    .clr_btn(clr_btn),
    .tgl_btn(tgl_btn),
    .j      (j),
    .k      (k),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  // Number of rising edges so far; read on falling edges only.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Button driven at the current falling edge: the next rising edge is edge 1
  // and j/k must first read high after edge DEB+2.
  task automatic expect_pulse(input logic [1:0] jk);
    exp_t e;
    e.jk    = jk;
    e.start = cyc + DEB + 2;
    q.push_back(e);
  endtask

  // Monitor: every rising j|k pulse must match the head of the queue in
  // value and start cycle, and must last exactly PULSE samples.
  logic       on_p = 1'b0;
  int         len  = 0;
  exp_t       cur;
  logic [1:0] cur_jk;

  always @(negedge clk) begin
    if (!reset) begin
      on_p = 1'b0;
      len  = 0;
    end else if (j | k) begin
      if (!on_p) begin
        on_p = 1'b1;
        len  = 1;
        cur_jk = {j, k};
        if (q.size() == 0) begin
          checks++;
          fails++;
          $display("FAIL unexpected_pulse actual jk=%b required no pulse (cycle %0d)", cur_jk, cyc);
        end else begin
          cur = q.pop_front();
          check("pulse_jk", int'(cur_jk), int'(cur.jk));
          check("pulse_start", cyc, cur.start);
        end
      end else begin
        len++;
      end
    end else if (on_p) begin
      on_p = 1'b0;
      check("pulse_len", len, PULSE);
    end
  end

  initial begin
    int c0;
    int r0;

    // 1: reset held with buttons toggling; outputs must stay zero.
    reset   = 1'b0;
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tgl_btn = 1'b0;
    #1;
    check("rst_out_initial", int'({j, k, busy}), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      set_btn = i[0];
      clr_btn = i[1];
      tgl_btn = i[2];
      #1;
      check("rst_out_toggling", int'({j, k, busy}), 0);
    end
    @(negedge clk);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    tgl_btn = 1'b0;
    reset   = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_after_reset", int'({j, k, busy}), 0);

    // 2: set press held, then released.
    @(negedge clk);
    set_btn = 1'b1;
    c0 = cyc;
    expect_pulse(2'b10);
    wait_until(c0 + 5);
    check("busy_before_edge6", int'(busy), 0);
    wait_until(c0 + 6);
    check("busy_after_edge6", int'(busy), 1);
    wait_until(c0 + 12);
    check("held_wait_release", int'({j, k, busy}), 3'b001);
    set_btn = 1'b0;
    r0 = cyc;
    wait_until(r0 + 5);
    check("busy_during_release_debounce", int'(busy), 1);
    wait_until(r0 + 8);
    check("busy_after_release", int'(busy), 0);

    // 3: clear bounce of 3 clocks must be ignored.
    @(negedge clk);
    clr_btn = 1'b1;
    repeat (3) @(negedge clk);
    clr_btn = 1'b0;
    repeat (15) @(negedge clk);
    check("bounce_ignored", int'({j, k, busy}), 0);

    // 4: set and clear in the same cycle give one j=k=1 command.
    @(negedge clk);
    set_btn = 1'b1;
    clr_btn = 1'b1;
    expect_pulse(2'b11);
    repeat (12) @(negedge clk);
    set_btn = 1'b0;
    clr_btn = 1'b0;
    repeat (12) @(negedge clk);
    check("both_released_idle", int'(busy), 0);

    // 5: toggle pressed while clear still held is dropped; later toggle works.
    @(negedge clk);
    clr_btn = 1'b1;
    expect_pulse(2'b01);
    repeat (10) @(negedge clk);
    tgl_btn = 1'b1;
    repeat (12) @(negedge clk);
    check("tgl_dropped_busy", int'({j, k, busy}), 3'b001);
    clr_btn = 1'b0;
    tgl_btn = 1'b0;
    repeat (12) @(negedge clk);
    check("released_after_drop", int'(busy), 0);
    @(negedge clk);
    tgl_btn = 1'b1;
    expect_pulse(2'b11);
    repeat (10) @(negedge clk);
    tgl_btn = 1'b0;
    repeat (12) @(negedge clk);
    check("tgl_done_idle", int'(busy), 0);

    // 6: reset mid-pulse clears outputs at once; nothing resumes afterwards.
    @(negedge clk);
    set_btn = 1'b1;
    c0 = cyc;
    expect_pulse(2'b10);
    wait_until(c0 + 6);
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_mid_pulse", int'({j, k, busy}), 0);
    set_btn = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (20) @(negedge clk);
    check("no_resume_after_reset", int'({j, k, busy}), 0);

    check("scoreboard_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule
